// File: rtl/sample_unpacker.sv
// Purpose : rebuilds samples from the packed 16-bit word stream and checks packet framing.
// Latency : the first sample of an accepted word appears 1 cycle after acceptance.
// Backpress: in_ready drops for one cycle whenever a word carries a second sample still to emit.
//
// Ports:
//   clk, reset          sample clock, synchronous active-high reset
//   mode                packing mode, latched at word index 0 (0: 3ch 2-bit I/Q, 1/2: 8-bit raw)
//   in_data/in_en/in_packet_end/in_ready   word stream; a word moves when in_en && in_ready
//   out_valid/out_iq/out_raw/out_first     one decoded sample per beat (registered)
//   packet_count/frame_err/err_count       framing statistics
module sample_unpacker #(
    parameter int WORDS_M0  = 720,
    parameter int WORDS_M12 = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  mode,
    input  logic [15:0] in_data,
    input  logic        in_en,
    input  logic        in_packet_end,
    output logic        in_ready,
    output logic        out_valid,
    output logic [11:0] out_iq,
    output logic [7:0]  out_raw,
    output logic        out_first,
    output logic [15:0] packet_count,
    output logic        frame_err,
    output logic [7:0]  err_count
);

    localparam int IDX_W = $clog2((WORDS_M0 > WORDS_M12) ? WORDS_M0 : WORDS_M12);
    localparam logic [IDX_W-1:0] LAST_M0  = IDX_W'(WORDS_M0 - 1);
    localparam logic [IDX_W-1:0] LAST_M12 = IDX_W'(WORDS_M12 - 1);

    // Word position inside a mode-0 three-word group.
    typedef enum logic [1:0] {
        PH_W0 = 2'd0,
        PH_W1 = 2'd1,
        PH_W2 = 2'd2
    } phase_t;

    phase_t             phase_q, phase_d;
    logic [7:0]         pkt_mode_q, pkt_mode_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [7:0]         hold_q, hold_d;
    logic               pend_vld_q, pend_vld_d;
    logic [11:0]        pend_dat_q, pend_dat_d;
    logic               out_valid_q, out_valid_d;
    logic [11:0]        out_iq_q, out_iq_d;
    logic [7:0]         out_raw_q, out_raw_d;
    logic               out_first_q, out_first_d;
    logic [15:0]        packet_count_q, packet_count_d;
    logic               frame_err_q, frame_err_d;
    logic [7:0]         err_count_q, err_count_d;

    logic               accept;
    logic [7:0]         cur_mode;
    logic               is_m0;
    logic               is_m12;
    logic               at_last;
    logic               first_word;

    // A word is only refused while its predecessor's second sample is still queued.
    assign in_ready   = ~pend_vld_q;
    assign accept     = in_en & in_ready;
    assign first_word = (word_idx_q == '0);
    // Index 0 uses the live mode so the very first word already decodes correctly.
    assign cur_mode   = first_word ? mode : pkt_mode_q;
    assign is_m0      = (cur_mode == 8'd0);
    assign is_m12     = (cur_mode == 8'd1) || (cur_mode == 8'd2);
    // Unsupported modes are framed like modes 1/2.
    assign at_last    = (word_idx_q == (is_m0 ? LAST_M0 : LAST_M12));

    always_comb begin
        phase_d        = phase_q;
        pkt_mode_d     = pkt_mode_q;
        word_idx_d     = word_idx_q;
        hold_d         = hold_q;
        pend_vld_d     = pend_vld_q;
        pend_dat_d     = pend_dat_q;
        out_valid_d    = 1'b0;
        out_iq_d       = out_iq_q;
        out_raw_d      = out_raw_q;
        out_first_d    = 1'b0;
        packet_count_d = packet_count_q;
        frame_err_d    = frame_err_q;
        err_count_d    = err_count_q;

        if (pend_vld_q) begin
            // Second sample of the previous word; pkt_mode_q already reflects that word.
            out_valid_d = 1'b1;
            pend_vld_d  = 1'b0;
            if (pkt_mode_q == 8'd0) begin
                out_iq_d  = pend_dat_q;
                out_raw_d = 8'd0;
            end else begin
                out_iq_d  = 12'd0;
                out_raw_d = pend_dat_q[7:0];
            end
        end else if (accept) begin
            pkt_mode_d = cur_mode;

            if (is_m0) begin
                out_valid_d = 1'b1;
                out_first_d = first_word;
                out_raw_d   = 8'd0;
                case (phase_q)
                    PH_W0: begin
                        out_iq_d = in_data[15:4];
                        hold_d   = {4'd0, in_data[3:0]};
                        phase_d  = PH_W1;
                    end
                    PH_W1: begin
                        out_iq_d = {hold_q[3:0], in_data[15:8]};
                        hold_d   = in_data[7:0];
                        phase_d  = PH_W2;
                    end
                    default: begin
                        out_iq_d   = {hold_q, in_data[15:12]};
                        pend_vld_d = 1'b1;
                        pend_dat_d = in_data[11:0];
                        hold_d     = 8'd0;
                        phase_d    = PH_W0;
                    end
                endcase
            end else if (is_m12) begin
                out_valid_d = 1'b1;
                out_first_d = first_word;
                out_iq_d    = 12'd0;
                out_raw_d   = in_data[15:8];
                pend_vld_d  = 1'b1;
                pend_dat_d  = {4'd0, in_data[7:0]};
            end

            // Framing: an end flag must coincide with the last expected word.
            // Any mismatch resyncs to index 0; samples of this word still go out.
            if (in_packet_end && at_last) begin
                packet_count_d = packet_count_q + 16'd1;
                word_idx_d     = '0;
                phase_d        = PH_W0;
                hold_d         = 8'd0;
            end else if (in_packet_end || at_last) begin
                frame_err_d = 1'b1;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
                word_idx_d = '0;
                phase_d    = PH_W0;
                hold_d     = 8'd0;
            end else begin
                word_idx_d = word_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q        <= PH_W0;
            pkt_mode_q     <= 8'd0;
            word_idx_q     <= '0;
            hold_q         <= 8'd0;
            pend_vld_q     <= 1'b0;
            pend_dat_q     <= 12'd0;
            out_valid_q    <= 1'b0;
            out_iq_q       <= 12'd0;
            out_raw_q      <= 8'd0;
            out_first_q    <= 1'b0;
            packet_count_q <= 16'd0;
            frame_err_q    <= 1'b0;
            err_count_q    <= 8'd0;
        end else begin
            phase_q        <= phase_d;
            pkt_mode_q     <= pkt_mode_d;
            word_idx_q     <= word_idx_d;
            hold_q         <= hold_d;
            pend_vld_q     <= pend_vld_d;
            pend_dat_q     <= pend_dat_d;
            out_valid_q    <= out_valid_d;
            out_iq_q       <= out_iq_d;
            out_raw_q      <= out_raw_d;
            out_first_q    <= out_first_d;
            packet_count_q <= packet_count_d;
            frame_err_q    <= frame_err_d;
            err_count_q    <= err_count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_iq       = out_iq_q;
    assign out_raw      = out_raw_q;
    assign out_first    = out_first_q;
    assign packet_count = packet_count_q;
    assign frame_err    = frame_err_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_sample_unpacker.sv
// Purpose : checks sample_unpacker against a bit-stream reference model, cycle by cycle.
// Latency : model schedules each decoded sample at acceptance+1 (and +2 for a second sample).
// Backpress: driver holds each word until it is accepted, bounded by a retry budget.
module tb_sample_unpacker;

    logic        clk;
    logic        reset;
    logic [7:0]  mode;
    logic [15:0] in_data;
    logic        in_en;
    logic        in_packet_end;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_iq;
    logic [7:0]  out_raw;
    logic        out_first;
    logic [15:0] packet_count;
    logic        frame_err;
    logic [7:0]  err_count;

    sample_unpacker #(.WORDS_M0(720), .WORDS_M12(480)) dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .in_data       (in_data),
        .in_en         (in_en),
        .in_packet_end (in_packet_end),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_iq        (out_iq),
        .out_raw       (out_raw),
        .out_first     (out_first),
        .packet_count  (packet_count),
        .frame_err     (frame_err),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic        raw;
        logic [11:0] val;
        logic        first;
    } exp_t;

    exp_t        q[$];
    exp_t        ent;
    int          cyc = 0;
    bit          chk_on = 0;
    int          m_idx;
    logic [7:0]  m_pmode;
    logic [63:0] mbuf;
    int          mnbits;
    logic [15:0] m_pkt;
    int          m_err;
    logic        m_ferr;
    int          busy_cyc;
    logic [11:0] m_iq;
    logic [7:0]  m_raw;
    logic        m_first;
    logic        exp_v;
    logic        exp_rdy;

    // Statistics used by the literal checks.
    int          beats, firsts, rdy_lo;
    bit          seq_on = 0;
    logic [11:0] seq_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_clear();
        q.delete();
        m_idx = 0; m_pmode = 8'd0; mbuf = 64'd0; mnbits = 0;
        m_pkt = 16'd0; m_err = 0; m_ferr = 1'b0; busy_cyc = -1;
        m_iq = 12'd0; m_raw = 8'd0; m_first = 1'b0;
    endtask

    // Word observed at this negedge is taken at the next posedge (cycle cyc+1).
    task automatic model_accept();
        int n, k;
        exp_t e;
        if (m_idx == 0) m_pmode = mode;
        n = (m_pmode == 8'd0) ? 720 : 480;
        k = 0;
        if (m_pmode == 8'd0) begin
            // Mode 0 is a plain MSB-first bit stream cut into 12-bit samples.
            mbuf   = (mbuf << 16) | {48'd0, in_data};
            mnbits = mnbits + 16;
            while (mnbits >= 12) begin
                e.cyc   = 32'(cyc + 1 + k);
                e.raw   = 1'b0;
                e.val   = 12'(mbuf >> (mnbits - 12));
                e.first = (k == 0) && (m_idx == 0);
                q.push_back(e);
                mnbits = mnbits - 12;
                k++;
            end
            mbuf = mbuf & ((64'd1 << mnbits) - 64'd1);
        end else if (m_pmode == 8'd1 || m_pmode == 8'd2) begin
            e.cyc = 32'(cyc + 1); e.raw = 1'b1; e.val = {4'd0, in_data[15:8]}; e.first = (m_idx == 0);
            q.push_back(e);
            e.cyc = 32'(cyc + 2); e.raw = 1'b1; e.val = {4'd0, in_data[7:0]};  e.first = 1'b0;
            q.push_back(e);
            k = 2;
        end
        if (k == 2) busy_cyc = cyc + 1;
        if (in_packet_end && m_idx == n - 1) begin
            m_pkt = m_pkt + 16'd1;
            m_idx = 0; mbuf = 64'd0; mnbits = 0;
        end else if (in_packet_end || m_idx == n - 1) begin
            m_ferr = 1'b1;
            if (m_err < 255) m_err++;
            m_idx = 0; mbuf = 64'd0; mnbits = 0;
        end else begin
            m_idx++;
        end
    endtask

    initial model_clear();

    // Compare process: every cycle, then advance the model with the current inputs.
    always @(negedge clk) begin
        exp_v = 1'b0;
        m_first = 1'b0;
        if (q.size() > 0 && q[0].cyc == 32'(cyc)) begin
            ent = q.pop_front();
            exp_v = 1'b1;
            m_first = ent.first;
            if (ent.raw) begin m_raw = ent.val[7:0]; m_iq = 12'd0; end
            else begin m_iq = ent.val; m_raw = 8'd0; end
        end
        exp_rdy = (busy_cyc != cyc);
        if (chk_on) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            chk("out_iq", {20'd0, out_iq}, {20'd0, m_iq});
            chk("out_raw", {24'd0, out_raw}, {24'd0, m_raw});
            chk("out_first", {31'd0, out_first}, {31'd0, m_first});
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("packet_count", {16'd0, packet_count}, {16'd0, m_pkt});
            chk("err_count", {24'd0, err_count}, 32'(m_err));
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
            if (out_valid === 1'b1) beats++;
            if (out_first === 1'b1) firsts++;
            if (in_ready === 1'b0) rdy_lo++;
            if (seq_on && out_valid === 1'b1) begin
                chk("seq_iq", {20'd0, out_iq}, {20'd0, seq_n});
                seq_n = seq_n + 12'd1;
            end
        end
        if (reset) model_clear();
        else if (in_en && exp_rdy) model_accept();
    end

    // ---------------- driver ----------------
    task automatic idle(input int n);
        in_en = 1'b0;
        in_packet_end = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_word(input logic [15:0] d, input logic e, input logic [7:0] m);
        bit acc;
        int tries;
        in_data = d; in_packet_end = e; mode = m; in_en = 1'b1;
        acc = 0; tries = 0;
        while (!acc && tries < 8) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            tries++;
            @(posedge clk); #1;
        end
        in_en = 1'b0;
        in_packet_end = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Mode-0 packer: samples (base+n) mod 4096, optional switch of the mode input mid-packet.
    task automatic send_m0_pat(input int base, input int nwords, input bit end_last,
                               input int on, input int off, input int switch_at);
        logic [11:0] s0, s1, s2, s3;
        logic [15:0] w;
        int run, g;
        run = 0;
        for (int i = 0; i < nwords; i++) begin
            g  = i / 3;
            s0 = 12'(base + 4 * g);
            s1 = 12'(base + 4 * g + 1);
            s2 = 12'(base + 4 * g + 2);
            s3 = 12'(base + 4 * g + 3);
            case (i % 3)
                0:       w = {s0, s1[11:8]};
                1:       w = {s1[7:0], s2[11:4]};
                default: w = {s2[3:0], s3};
            endcase
            send_word(w, end_last && (i == nwords - 1),
                      (switch_at >= 0 && i >= switch_at) ? 8'd1 : 8'd0);
            run++;
            if (on > 0 && run == on) begin run = 0; idle(off); end
        end
    endtask

    task automatic send_gen(input logic [7:0] m, input int nwords, input bit end_last,
                            input int on, input int off, input bit fixed_en, input logic [15:0] fixed);
        int run;
        run = 0;
        for (int i = 0; i < nwords; i++) begin
            send_word(fixed_en ? fixed : 16'($urandom), end_last && (i == nwords - 1), m);
            run++;
            if (on > 0 && run == on) begin run = 0; idle(off); end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_en = 1'b0; in_packet_end = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic clr_stats();
        beats = 0; firsts = 0; rdy_lo = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rm;
        int rn;
        bit rel;
        reset = 1'b1; mode = 8'd0; in_data = 16'd0; in_en = 1'b0; in_packet_end = 1'b0;
        clr_stats(); seq_n = 12'd0;
        do_reset();
        chk_on = 1;

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_first", {31'd0, out_first}, 32'd0);
        chk("rst_out_iq", {20'd0, out_iq}, 32'd0);
        chk("rst_out_raw", {24'd0, out_raw}, 32'd0);
        chk("rst_packet_count", {16'd0, packet_count}, 32'd0);
        chk("rst_err", {23'd0, err_count, frame_err}, 32'd0);

        // 1: mode 0, incrementing pattern, 3-of-4 cadence
        clr_stats(); seq_on = 1; seq_n = 12'd0;
        send_m0_pat(0, 720, 1, 3, 1, -1);
        idle(4); seq_on = 0;
        chk("t1_beats", 32'(beats), 32'd960);
        chk("t1_firsts", 32'(firsts), 32'd1);
        chk("t1_packets", {16'd0, packet_count}, 32'd1);
        chk("t1_frame_err", {31'd0, frame_err}, 32'd0);

        // 2: mode 1, A5/3C, 2-of-4 cadence, 3 packets
        do_reset(); clr_stats();
        repeat (3) send_gen(8'd1, 480, 1, 2, 2, 1, 16'hA53C);
        idle(4);
        chk("t2_beats", 32'(beats), 32'd2880);
        chk("t2_last_raw", {24'd0, out_raw}, 32'h3C);
        chk("t2_packets", {16'd0, packet_count}, 32'd3);

        // 3: mode 0 back-to-back, random data
        do_reset(); clr_stats();
        send_gen(8'd0, 720, 1, 0, 0, 0, 16'd0);
        idle(4);
        chk("t3_beats", 32'(beats), 32'd960);
        chk("t3_ready_drops", 32'(rdy_lo), 32'd240);
        chk("t3_packets", {16'd0, packet_count}, 32'd1);

        // 4: early end at word 100, then a clean packet
        do_reset();
        send_m0_pat(0, 101, 1, 0, 0, -1);
        idle(3);
        chk("t4_frame_err", {31'd0, frame_err}, 32'd1);
        chk("t4_err_count", {24'd0, err_count}, 32'd1);
        clr_stats();
        send_m0_pat(100, 720, 1, 3, 1, -1);
        idle(4);
        chk("t4_packets", {16'd0, packet_count}, 32'd1);
        chk("t4_firsts", 32'(firsts), 32'd1);

        // 5: mode input flips to 1 at word 300; next packet in mode 1
        do_reset(); clr_stats();
        send_m0_pat(0, 720, 1, 0, 0, 300);
        idle(3);
        chk("t5_m0_beats", 32'(beats), 32'd960);
        send_gen(8'd1, 480, 1, 0, 0, 0, 16'd0);
        idle(4);
        chk("t5_packets", {16'd0, packet_count}, 32'd2);
        chk("t5_frame_err", {31'd0, frame_err}, 32'd0);

        // err_count saturation: 300 single-word packets, each misframed
        repeat (300) send_gen(8'd1, 1, 1, 0, 0, 0, 16'd0);
        idle(3);
        chk("sat_err_count", {24'd0, err_count}, 32'd255);
        chk("sat_packets", {16'd0, packet_count}, 32'd2);

        // 6: reset while s3 is pending
        send_m0_pat(0, 3, 0, 0, 0, -1);
        chk("t6_pending_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t6_counters", {packet_count, err_count, 7'd0, frame_err}, 32'd0);
        clr_stats(); seq_on = 1; seq_n = 12'd0;
        send_m0_pat(0, 720, 1, 0, 0, -1);
        idle(4); seq_on = 0;
        chk("t6_beats", 32'(beats), 32'd960);
        chk("t6_packets", {16'd0, packet_count}, 32'd1);

        // Random mix: modes 0..3, short misframed packets, overruns, random cadence
        do_reset();
        for (int p = 0; p < 12; p++) begin
            rm = 8'($urandom_range(0, 3));
            rn = (rm == 8'd0) ? 720 : 480;
            if ($urandom_range(0, 2) == 0) begin
                rn  = $urandom_range(1, 60);
                rel = 1;
            end else begin
                rel = ($urandom_range(0, 3) != 0);
            end
            send_gen(rm, rn, rel, $urandom_range(0, 4), $urandom_range(0, 2), 0, 16'd0);
            idle($urandom_range(0, 3));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
